// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Instruction-fetch front end. Fetches words from a variable-latency
//            instruction memory and queues {pc, instr} pairs for decode.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DROP  = 2'd2;

    logic [1:0]         r_state;
    logic               r_req;
    logic [31:0]        r_addr;
    logic [31:0]        r_fetch_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];

    logic               w_ack;
    logic               w_push;
    logic               w_pop;
    logic               w_can_issue;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [31:0]        w_next_pc;
    logic               w_unused_flush_lsb;

    assign w_unused_flush_lsb = ^flush_pc_i[1:0];

    assign w_ack  = r_req & imem_ack_i;
    // Data returning in DROP belongs to the stale stream and is never queued.
    assign w_push = (r_state == c_ST_FETCH) & w_ack & ~flush_i;
    assign w_pop  = instr_valid_o & instr_ready_i & ~flush_i;

    always_comb begin
        w_cnt_next = r_count;
        if (flush_i) begin
            w_cnt_next = '0;
        end else if (w_push && !w_pop) begin
            w_cnt_next = r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_cnt_next = r_count - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_next_pc = r_fetch_pc;
        if (flush_i) begin
            w_next_pc = {flush_pc_i[31:2], 2'b00};
        end else if (w_push) begin
            w_next_pc = r_addr + 32'd4;
        end
    end

    assign w_can_issue = start_i & (w_cnt_next < c_DEPTH);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= c_ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_fetch_pc <= w_next_pc;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_can_issue) begin
                        r_req   <= 1'b1;
                        r_addr  <= w_next_pc;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH, c_ST_DROP: begin
                    if (w_ack) begin
                        if (w_can_issue) begin
                            r_addr  <= w_next_pc;
                            r_state <= c_ST_FETCH;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end else if (flush_i) begin
                        // Old request must still finish on the bus; its data is dropped.
                        r_state <= c_ST_DROP;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_cnt_next;
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= r_addr;
                r_instr_mem[r_wr_ptr] <= imem_data_i;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = (r_count != '0);
    assign instr_o       = r_instr_mem[r_rd_ptr];
    assign pc_o          = r_pc_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_queue
// Brief    : Self-checking bench for if_prefetch_queue with a queue-based
//            reference model and randomized memory/decode/redirect traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i         = 1'b0;
    logic        rst_i         = 1'b0;
    logic        start_i       = 1'b0;
    logic        imem_ack_i    = 1'b0;
    logic        instr_ready_i = 1'b0;
    logic        flush_i       = 1'b0;
    logic [31:0] flush_pc_i    = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int wait_w   = 0;
    int wcnt     = 0;
    int acks     = 0;
    bit rand_mode = 1'b0;
    bit cmp_en    = 1'b0;

    // Reference: queue of {pc, instr}, plus the single outstanding bus request.
    logic [63:0] mq[$];
    bit          m_req  = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_addr = RESET_PC;
    logic [31:0] m_fpc  = RESET_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of memory behaviour: wait_w wait states per fetch, then ack.
    task automatic cyc();
        @(negedge clk_i);
        if (imem_req_o) begin
            if (wcnt >= wait_w) begin
                imem_ack_i = 1'b1;
                wcnt = 0;
                acks++;
                if (rand_mode) wait_w = $urandom_range(0, 3);
            end else begin
                imem_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack_i = rand_mode && ($urandom_range(0, 3) == 0);
            wcnt = 0;
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        start_i = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (!imem_req_o && !instr_valid_o) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        bit ack;
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                mq.delete();
                m_req  = 1'b0;
                m_drop = 1'b0;
                m_addr = RESET_PC;
                m_fpc  = RESET_PC;
            end else begin
                ack = m_req && imem_ack_i;
                if (flush_i) begin
                    mq.delete();
                    m_fpc = {flush_pc_i[31:2], 2'b00};
                    if (m_req && !ack) begin
                        m_drop = 1'b1;
                    end else begin
                        m_req  = 1'b0;
                        m_drop = 1'b0;
                    end
                end else begin
                    if (mq.size() > 0 && instr_ready_i) void'(mq.pop_front());
                    if (ack) begin
                        if (!m_drop) begin
                            mq.push_back({m_addr, mem_word(m_addr)});
                            m_fpc = m_addr + 32'd4;
                        end
                        m_drop = 1'b0;
                        m_req  = 1'b0;
                    end
                end
                if (!m_req && start_i && mq.size() < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_fpc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && cmp_en) begin
                chk("cmp_valid", 32'(instr_valid_o), 32'(mq.size() > 0));
                if (mq.size() > 0) begin
                    chk("cmp_pc", pc_o, mq[0][63:32]);
                    chk("cmp_instr", instr_o, mq[0][31:0]);
                end
                chk("cmp_req", 32'(imem_req_o), 32'(m_req));
                if (m_req) chk("cmp_addr", imem_addr_o, m_addr);
            end
        end
    end

    initial begin
        bit found;
        int hold;

        // Reset values
        #12;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        cyc();
        rst_i = 1'b1;
        cmp_en = 1'b1;

        // Zero-wait streaming
        cyc();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        cyc();
        chk("start_req", 32'(imem_req_o), 32'd1);
        chk("start_addr", imem_addr_o, 32'h0);
        chk("start_valid", 32'(instr_valid_o), 32'd0);
        cyc();
        chk("stream_valid0", 32'(instr_valid_o), 32'd1);
        chk("stream_pc0", pc_o, 32'h0);
        chk("stream_instr0", instr_o, mem_word(32'h0));
        chk("stream_addr4", imem_addr_o, 32'h4);
        cyc();
        chk("stream_pc4", pc_o, 32'h4);
        chk("stream_instr4", instr_o, mem_word(32'h4));
        chk("stream_addr8", imem_addr_o, 32'h8);

        // Fill with decode stalled, then one pop allows exactly one refetch
        wait_idle("idle_before_fill");
        wait_w = 0;
        flush_i = 1'b1;
        flush_pc_i = 32'h0;
        cyc();
        flush_i = 1'b0;
        acks = 0;
        start_i = 1'b1;
        instr_ready_i = 1'b0;
        repeat (12) cyc();
        chk("fill_acks", 32'(acks), 32'd4);
        chk("fill_req_low", 32'(imem_req_o), 32'd0);
        chk("fill_head_pc", pc_o, 32'h0);
        instr_ready_i = 1'b1;
        cyc();
        instr_ready_i = 1'b0;
        chk("refill_req", 32'(imem_req_o), 32'd1);
        chk("refill_addr", imem_addr_o, 32'h10);
        chk("refill_head_pc", pc_o, 32'h4);
        repeat (6) cyc();
        chk("refill_acks", 32'(acks), 32'd5);
        chk("refill_req_low", 32'(imem_req_o), 32'd0);

        // Flush while the fetch at 8 is waiting
        wait_idle("idle_before_drop");
        wait_w = 2;
        flush_i = 1'b1;
        flush_pc_i = 32'h0;
        cyc();
        flush_i = 1'b0;
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (imem_req_o && imem_addr_o == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        chk("drop_found8", 32'(found), 32'd1);
        flush_i = 1'b1;
        flush_pc_i = 32'h0000_0103;
        cyc();
        flush_i = 1'b0;
        chk("drop_valid", 32'(instr_valid_o), 32'd0);
        chk("drop_req_held", 32'(imem_req_o), 32'd1);
        chk("drop_addr_held", imem_addr_o, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (imem_req_o && imem_addr_o != 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        chk("drop_next_req", 32'(found), 32'd1);
        chk("drop_next_addr", imem_addr_o, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (instr_valid_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("drop_first_valid", 32'(found), 32'd1);
        chk("drop_first_pc", pc_o, 32'h100);
        chk("drop_first_instr", instr_o, mem_word(32'h100));

        // Flush coinciding with ack and pop
        wait_w = 0;
        repeat (4) cyc();
        chk("coinc_pre_valid", 32'(instr_valid_o), 32'd1);
        chk("coinc_pre_ack", 32'(imem_ack_i), 32'd1);
        flush_i = 1'b1;
        flush_pc_i = 32'h0000_0200;
        cyc();
        flush_i = 1'b0;
        chk("coinc_valid", 32'(instr_valid_o), 32'd0);
        chk("coinc_req", 32'(imem_req_o), 32'd1);
        chk("coinc_addr", imem_addr_o, 32'h200);
        cyc();
        chk("coinc_next_valid", 32'(instr_valid_o), 32'd1);
        chk("coinc_next_pc", pc_o, 32'h200);

        // Three wait states: each address held four cycles
        wait_idle("idle_before_wait3");
        wait_w = 3;
        flush_i = 1'b1;
        flush_pc_i = 32'h0000_0300;
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        hold = 0;
        repeat (24) begin
            cyc();
            if (imem_req_o && imem_addr_o == 32'h304) hold++;
        end
        chk("wait3_hold", 32'(hold), 32'd4);

        // Randomized traffic against the model
        rand_mode = 1'b1;
        repeat (3000) begin
            cyc();
            start_i       = ($urandom_range(0, 7) != 0);
            instr_ready_i = ($urandom_range(0, 3) != 0);
            flush_i       = ($urandom_range(0, 15) == 0);
            flush_pc_i    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
        end
        rand_mode = 1'b0;
        flush_i = 1'b0;

        // Asynchronous reset in the middle of a fetch
        wait_w = 3;
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (imem_req_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_req_seen", 32'(found), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req_o), 32'd0);
        chk("mid_rst_addr", imem_addr_o, RESET_PC);
        chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("mid_rst_instr", instr_o, 32'h0);
        chk("mid_rst_pc", pc_o, 32'h0);
        cyc();
        cyc();
        rst_i = 1'b1;
        wait_w = 0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (imem_req_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("resume_req", 32'(found), 32'd1);
        chk("resume_addr", imem_addr_o, RESET_PC);
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
